// File: rtl/nlms_axi_pkg.sv
// nlms_axi_pkg: AXI response/burst constants, reader FSM states and
// a response-classification helper shared by the NLMS fetch path.
package nlms_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        CREDIT,
        ADDR,
        DATA,
        DRAIN
    } reader_state_t;

    // EXOKAY is unexpected for a plain read, so it counts as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        err = 1'b1;
        unique case (resp)
            RESP_OKAY:   err = 1'b0;
            RESP_EXOKAY,
            RESP_SLVERR,
            RESP_DECERR: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/nlms_sync_fifo.sv
// nlms_sync_fifo: single-clock FIFO, register-array storage.
// Ports: clk/rst_n, push/wdata, pop/rdata, full, empty, count.
module nlms_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count
                   + (AW+1)'(do_push)
                   - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/nlms_axi_burst_reader.sv
// nlms_axi_burst_reader: AXI4 read master fetching a sample block and
// streaming it out on AXI4-Stream. Ports: ACLK/ARESETN, start/base_addr/
// num_beats, busy/done/rd_error, M_AXI_AR*, M_AXI_R*, M_AXIS_T*.
module nlms_axi_burst_reader
    import nlms_axi_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_BURST_LEN      = 8,
    parameter int C_FIFO_DEPTH     = 16,
    parameter int C_CNT_WIDTH      = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        start,
    input  logic [C_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [C_CNT_WIDTH-1:0]      num_beats,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_error,
    output logic [C_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    output logic                        M_AXIS_TLAST,
    input  logic                        M_AXIS_TREADY
);

    localparam int FCW = $clog2(C_FIFO_DEPTH) + 1;
    localparam int EW  = C_CNT_WIDTH + 1;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE =
        (C_CNT_WIDTH)'(1);
    localparam logic [C_CNT_WIDTH-1:0] CNT_BURST =
        (C_CNT_WIDTH)'(C_BURST_LEN);

    reader_state_t               state;
    logic [C_AXI_ADDR_WIDTH-1:0] addr;
    logic [C_AXI_ADDR_WIDTH-1:0] burst_bytes;
    logic [C_CNT_WIDTH-1:0]      remaining;
    logic [C_CNT_WIDTH-1:0]      left_to_stream;
    logic [C_CNT_WIDTH-1:0]      burst_cnt;
    logic [C_CNT_WIDTH-1:0]      len;
    logic [EW-1:0]               free_slots;
    logic [EW-1:0]               need;
    logic [FCW-1:0]              fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        last_beat;
    logic                        sig_unused;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARSIZE  = SIZE_4B;
    assign M_AXI_ARBURST = BURST_INCR;

    assign len = (remaining > CNT_BURST) ? CNT_BURST : remaining;

    // burst_cnt holds beats already committed to the FIFO but not yet
    // received, so the credit check stays safe if bursts ever overlap.
    assign free_slots = (EW)'(C_FIFO_DEPTH) - (EW)'(fifo_count);
    assign need       = (EW)'(len) + (EW)'(burst_cnt);

    assign burst_bytes = (C_AXI_ADDR_WIDTH)'(burst_cnt) << 2;
    assign last_beat   = (burst_cnt == CNT_ONE);

    assign fifo_push     = M_AXI_RVALID && M_AXI_RREADY;
    assign M_AXIS_TVALID = !fifo_empty;
    assign fifo_pop      = M_AXIS_TVALID && M_AXIS_TREADY;
    assign M_AXIS_TLAST  = M_AXIS_TVALID
                        && (left_to_stream == CNT_ONE);

    // RID is not checked (single ID); full is covered by the credit.
    assign sig_unused = ^{M_AXI_RID, fifo_full};

    nlms_sync_fifo #(
        .WIDTH (C_AXI_DATA_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (fifo_push),
        .wdata (M_AXI_RDATA),
        .pop   (fifo_pop),
        .rdata (M_AXIS_TDATA),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            rd_error       <= 1'b0;
            addr           <= '0;
            remaining      <= '0;
            left_to_stream <= '0;
            burst_cnt      <= '0;
            M_AXI_ARVALID  <= 1'b0;
            M_AXI_ARADDR   <= '0;
            M_AXI_ARLEN    <= '0;
            M_AXI_RREADY   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fifo_pop) begin
                left_to_stream <= left_to_stream - CNT_ONE;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rd_error       <= 1'b0;
                        addr           <= base_addr;
                        remaining      <= num_beats;
                        left_to_stream <= num_beats;
                        if (num_beats == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= CREDIT;
                        end
                    end
                end
                CREDIT: begin
                    if (free_slots >= need) begin
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_ARADDR  <= addr;
                        M_AXI_ARLEN   <= 8'(len - CNT_ONE);
                        burst_cnt     <= len;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        addr          <= addr + burst_bytes;
                        remaining     <= remaining - burst_cnt;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    // Own beat counter decides the burst end; a
                    // misplaced RLAST is only flagged.
                    if (M_AXI_RVALID) begin
                        burst_cnt <= burst_cnt - CNT_ONE;
                        if (resp_is_err(M_AXI_RRESP)
                            || (M_AXI_RLAST != last_beat)) begin
                            rd_error <= 1'b1;
                        end
                        if (last_beat) begin
                            M_AXI_RREADY <= 1'b0;
                            state <= (remaining != '0)
                                   ? CREDIT : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (left_to_stream == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nlms_axi_burst_reader.sv
// tb_nlms_axi_burst_reader: AXI slave model plus stream scoreboard
// for the burst reader; one summary line at the end.
module tb_nlms_axi_burst_reader;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic        ACLK;
    logic        ARESETN;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_beats;
    logic        busy;
    logic        done;
    logic        rd_error;
    logic [0:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [0:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] TDATA;
    logic        TVALID;
    logic        TLAST;
    logic        TREADY;

    exp_t exp_q[$];
    ar_t  ar_log[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int r_total   = 0;
    int r_left    = 0;
    int level     = 0;
    bit r_hold    = 0;
    logic [31:0] r_addr = 0;

    bit abort     = 1;
    bit bp_mode   = 0;
    int bp_from   = 0;
    int err_idx   = -1;
    int beat_base = 0;
    int ar_base   = 0;
    int done_base = 0;

    nlms_axi_burst_reader dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .base_addr     (base_addr),
        .num_beats     (num_beats),
        .busy          (busy),
        .done          (done),
        .rd_error      (rd_error),
        .M_AXI_ARID    (ARID),
        .M_AXI_ARADDR  (ARADDR),
        .M_AXI_ARLEN   (ARLEN),
        .M_AXI_ARSIZE  (ARSIZE),
        .M_AXI_ARBURST (ARBURST),
        .M_AXI_ARVALID (ARVALID),
        .M_AXI_ARREADY (ARREADY),
        .M_AXI_RID     (RID),
        .M_AXI_RDATA   (RDATA),
        .M_AXI_RRESP   (RRESP),
        .M_AXI_RLAST   (RLAST),
        .M_AXI_RVALID  (RVALID),
        .M_AXI_RREADY  (RREADY),
        .M_AXIS_TDATA  (TDATA),
        .M_AXIS_TVALID (TVALID),
        .M_AXIS_TLAST  (TLAST),
        .M_AXIS_TREADY (TREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Runs at every negedge: decides inputs for the coming posedge
    // and predicts the handshakes that posedge will perform.
    task automatic tb_step();
        exp_t e;
        bit   acc;
        cyc++;
        if (abort) begin
            ARREADY = 1'b0;
            RVALID  = 1'b0;
            RLAST   = 1'b0;
            RRESP   = 2'b00;
            RDATA   = '0;
            TREADY  = 1'b1;
            r_left  = 0;
            r_hold  = 0;
            level   = 0;
            exp_q.delete();
            return;
        end
        if (done) done_cnt++;

        TREADY = !bp_mode
              || ((cyc - bp_from) >= 40 && (cyc % 2) == 1);
        if (TVALID && TREADY) begin
            if (exp_q.size() == 0) begin
                check("stray_beat", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("tdata", TDATA, e.data);
                check("tlast", 32'(TLAST), 32'(e.last));
            end
            level--;
        end

        if (!r_hold) begin
            if (r_left > 0 && $urandom_range(0, 3) != 0) begin
                RVALID = 1'b1;
                RDATA  = r_addr / 4 + 1;
                RLAST  = (r_left == 1);
                RRESP  = ((r_total - beat_base) == err_idx)
                       ? 2'b10 : 2'b00;
            end else begin
                RVALID = 1'b0;
                RLAST  = 1'b0;
                RRESP  = 2'b00;
            end
        end
        acc    = RVALID && RREADY;
        r_hold = RVALID && !acc;
        if (acc) begin
            r_addr = r_addr + 4;
            r_left--;
            r_total++;
            level++;
            check("fifo_space", 32'(level <= DEPTH), 1);
        end

        ARREADY = ARVALID && ($urandom_range(0, 1) == 1);
        if (ARVALID && ARREADY) begin
            ar_log.push_back('{ARADDR, ARLEN});
            r_addr = ARADDR;
            r_left = int'(ARLEN) + 1;
        end
    endtask

    initial forever begin
        @(negedge ACLK);
        tb_step();
    end

    task automatic start_block(input logic [31:0] base,
                               input int n);
        exp_t e;
        @(negedge ACLK);
        ar_base   = ar_log.size();
        done_base = done_cnt;
        beat_base = r_total;
        bp_from   = cyc;
        for (int i = 0; i < n; i++) begin
            e.data = base / 4 + i + 1;
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        start     = 1'b1;
        base_addr = base;
        num_beats = 16'(n);
        @(negedge ACLK);
        start = 1'b0;
        check("busy_set", 32'(busy), 1);
    endtask

    task automatic wait_block();
        for (int k = 0; k < 3000; k++) begin
            @(posedge ACLK);
            if (done_cnt != done_base) break;
        end
        check("done_seen", 32'(done_cnt != done_base), 1);
        repeat (3) @(posedge ACLK);
        check("done_once", 32'(done_cnt - done_base), 1);
        check("all_streamed", 32'(exp_q.size()), 0);
        check("busy_clr", 32'(busy), 0);
        exp_q.delete();
    endtask

    task automatic check_ar(input int idx,
                            input logic [31:0] a,
                            input logic [7:0] l);
        check("araddr", ar_log[ar_base + idx].addr, a);
        check("arlen", 32'(ar_log[ar_base + idx].len), 32'(l));
    endtask

    initial begin
        ARESETN   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_beats = '0;
        RID       = '0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        RRESP     = 2'b00;
        RDATA     = '0;
        TREADY    = 1'b1;

        repeat (3) @(negedge ACLK);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(rd_error), 0);
        check("rst_arvalid", 32'(ARVALID), 0);
        check("rst_rready", 32'(RREADY), 0);
        check("rst_tvalid", 32'(TVALID), 0);
        check("rst_tdata", TDATA, 0);
        check("rst_araddr", ARADDR, 0);
        check("arsize", 32'(ARSIZE), 2);
        check("arburst", 32'(ARBURST), 1);
        check("arid", 32'(ARID), 0);
        ARESETN = 1'b1;
        @(posedge ACLK);
        abort = 1'b0;

        // basic single burst
        start_block(32'h0, 8);
        wait_block();
        check("b_ar_cnt", 32'(ar_log.size() - ar_base), 1);
        check_ar(0, 32'h0, 8'd7);
        check("b_err", 32'(rd_error), 0);

        // three bursts with a short tail
        start_block(32'h40, 20);
        wait_block();
        check("m_ar_cnt", 32'(ar_log.size() - ar_base), 3);
        check_ar(0, 32'h40, 8'd7);
        check_ar(1, 32'h60, 8'd7);
        check_ar(2, 32'h80, 8'd3);

        // stream backpressure
        bp_mode = 1'b1;
        start_block(32'h0, 32);
        wait_block();
        bp_mode = 1'b0;
        check("bp_ar_cnt", 32'(ar_log.size() - ar_base), 4);

        // SLVERR on the third beat
        err_idx = 2;
        start_block(32'h0, 8);
        wait_block();
        err_idx = -1;
        check("e_err_set", 32'(rd_error), 1);

        // zero length; also clears the sticky error
        @(negedge ACLK);
        ar_base   = ar_log.size();
        start     = 1'b1;
        base_addr = 32'h0;
        num_beats = 16'd0;
        @(negedge ACLK);
        start = 1'b0;
        check("z_done", 32'(done), 1);
        check("z_busy", 32'(busy), 0);
        check("z_err_clr", 32'(rd_error), 0);
        @(negedge ACLK);
        check("z_done_pulse", 32'(done), 0);
        repeat (5) @(negedge ACLK);
        check("z_no_ar", 32'(ar_log.size() - ar_base), 0);

        // start while busy is ignored
        start_block(32'h20, 8);
        repeat (3) @(negedge ACLK);
        start     = 1'b1;
        base_addr = 32'h100;
        num_beats = 16'd4;
        @(negedge ACLK);
        start = 1'b0;
        wait_block();
        check("i_ar_cnt", 32'(ar_log.size() - ar_base), 1);
        check_ar(0, 32'h20, 8'd7);

        // asynchronous reset in the middle of a burst
        start_block(32'h0, 16);
        for (int k = 0; k < 500; k++) begin
            @(posedge ACLK);
            if (r_total - beat_base >= 3) break;
        end
        check("r_reached", 32'(r_total - beat_base >= 3), 1);
        @(negedge ACLK);
        #2;
        ARESETN = 1'b0;
        abort   = 1'b1;
        #1;
        check("r_arvalid", 32'(ARVALID), 0);
        check("r_rready", 32'(RREADY), 0);
        check("r_tvalid", 32'(TVALID), 0);
        check("r_tlast", 32'(TLAST), 0);
        check("r_busy", 32'(busy), 0);
        check("r_tdata", TDATA, 0);
        repeat (3) @(negedge ACLK);
        #2;
        ARESETN = 1'b1;
        @(posedge ACLK);
        abort = 1'b0;
        start_block(32'h0, 8);
        wait_block();
        check("r_ar_cnt", 32'(ar_log.size() - ar_base), 1);
        check_ar(0, 32'h0, 8'd7);
        check("r_err", 32'(rd_error), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
